// File: rtl/clint_pkg.sv
// Shared offsets, select encoding and address decode for the multi-hart CLINT.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CTRL_OFS      = 16'hBFF0;
  localparam logic [15:0] MTIME_LO_OFS  = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFS  = 16'hBFFC;

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    MSIP,
    CMP,
    CTRL,
    MTIME_LO,
    MTIME_HI,
    NONE
  } clint_sel_e;

  typedef struct packed {
    clint_sel_e       sel;
    logic [IDX_W-1:0] idx;
  } clint_dec_t;

  // Maps a 16-bit offset to a register class and hart index; out-of-range harts map to NONE.
  function automatic clint_dec_t clint_decode(input logic [15:0] ofs, input int unsigned harts);
    clint_dec_t dec;
    dec.sel = NONE;
    dec.idx = '0;
    if (ofs == CTRL_OFS) begin
      dec.sel = CTRL;
    end else if (ofs == MTIME_LO_OFS) begin
      dec.sel = MTIME_LO;
    end else if (ofs == MTIME_HI_OFS) begin
      dec.sel = MTIME_HI;
    end else if (ofs[1:0] == 2'b00) begin
      if (ofs < MTIMECMP_BASE) begin
        if (32'((ofs - MSIP_BASE) >> 2) < harts) begin
          dec.sel = MSIP;
          dec.idx = IDX_W'((ofs - MSIP_BASE) >> 2);
        end
      end else if (32'((ofs - MTIMECMP_BASE) >> 3) < harts) begin
        dec.sel = CMP;
        dec.idx = IDX_W'((ofs - MTIMECMP_BASE) >> 3);
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk_i down to a one-cycle mtime tick every TICK_DIV running cycles.
module clint_prescaler
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  assign tick_c_o = run_i && (tick_cnt_q == CNT_MAX);

  // Counter freezes while stopped so the phase resumes where it left off.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_c_o) begin
      tick_cnt_d = '0;
    end else if (run_i) begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/clint_mp.sv
// Multi-hart core-local interruptor: msip/mtimecmp/mtime/ctrl registers with registered IRQs.
module clint_mp
  import clint_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CORE_NUMS = 4,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [XLEN-1:0]      addr_i,
  input  logic [XLEN-1:0]      data_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 data_ready_o,
  output logic                 err_o,
  output logic [CORE_NUMS-1:0] tmr_irq_o,
  output logic [CORE_NUMS-1:0] sft_irq_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TIME_W = 64;

  clint_dec_t           dec;
  logic                 wr;
  logic                 rd;
  logic [WORD_W-1:0]    wdata;
  logic [WORD_W-1:0]    rdata;
  logic                 tick;
  logic                 unused_addr;

  logic                 run_q;
  logic [CORE_NUMS-1:0] msip_q;
  logic [TIME_W-1:0]    cmp_q [CORE_NUMS];
  logic [TIME_W-1:0]    mtime_q;
  logic [TIME_W-1:0]    mtime_d;
  logic [TIME_W-1:0]    mtime_inc;
  logic [WORD_W-1:0]    shadow_q;
  logic [CORE_NUMS-1:0] tmr_d;
  logic [CORE_NUMS-1:0] tmr_q;
  logic [CORE_NUMS-1:0] sft_q;
  logic [XLEN-1:0]      data_q;
  logic                 ready_q;
  logic                 err_q;

  assign unused_addr = ^addr_i[XLEN-1:16];
  assign dec   = clint_decode(addr_i[15:0], CORE_NUMS);
  assign wr    = en_i && we_i;
  assign rd    = en_i && !we_i;
  assign wdata = data_i[WORD_W-1:0];

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .run_i    (run_q),
    .tick_c_o (tick)
  );

  // Read mux; mtime high always comes from the shadow captured by the last low read.
  always_comb begin
    rdata = '0;
    case (dec.sel)
      MSIP: begin
        for (int unsigned h = 0; h < CORE_NUMS; h++) begin
          if (dec.idx == IDX_W'(h)) rdata = WORD_W'(msip_q[h]);
        end
      end
      CMP: begin
        for (int unsigned h = 0; h < CORE_NUMS; h++) begin
          if (dec.idx == IDX_W'(h)) rdata = addr_i[2] ? cmp_q[h][63:32] : cmp_q[h][31:0];
        end
      end
      CTRL:     rdata = WORD_W'(run_q);
      MTIME_LO: rdata = mtime_q[31:0];
      MTIME_HI: rdata = shadow_q;
      default:  rdata = '0;
    endcase
  end

  // A word write beats the increment for that word; the high word never sees a carry that cycle.
  always_comb begin
    mtime_inc = mtime_q + TIME_W'(tick);
    mtime_d   = mtime_inc;
    if (wr && dec.sel == MTIME_LO) begin
      mtime_d = {mtime_q[63:32], wdata};
    end else if (wr && dec.sel == MTIME_HI) begin
      mtime_d = {wdata, mtime_inc[31:0]};
    end
  end

  always_comb begin
    tmr_d = '0;
    for (int unsigned h = 0; h < CORE_NUMS; h++) begin
      tmr_d[h] = (cmp_q[h] != '0) && (mtime_q >= cmp_q[h]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q    <= 1'b1;
      msip_q   <= '0;
      for (int unsigned h = 0; h < CORE_NUMS; h++) cmp_q[h] <= '0;
      mtime_q  <= '0;
      shadow_q <= '0;
      tmr_q    <= '0;
      sft_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= en_i;
      err_q   <= en_i && (dec.sel == NONE);
      mtime_q <= mtime_d;
      tmr_q   <= tmr_d;
      sft_q   <= msip_q;
      if (rd) data_q <= XLEN'(rdata);
      if (rd && dec.sel == MTIME_LO) shadow_q <= mtime_q[63:32];
      if (wr && dec.sel == CTRL) run_q <= wdata[0];
      for (int unsigned h = 0; h < CORE_NUMS; h++) begin
        if (wr && dec.sel == MSIP && dec.idx == IDX_W'(h)) msip_q[h] <= wdata[0];
        if (wr && dec.sel == CMP && dec.idx == IDX_W'(h)) begin
          if (addr_i[2]) cmp_q[h][63:32] <= wdata;
          else           cmp_q[h][31:0]  <= wdata;
        end
      end
    end
  end

  assign data_o       = data_q;
  assign data_ready_o = ready_q;
  assign err_o        = err_q;
  assign tmr_irq_o    = tmr_q;
  assign sft_irq_o    = sft_q;

endmodule

// File: tb/tb_clint_mp.sv
// Self-checking bench for clint_mp: vector table, directed corner sequences and random traffic vs a reference model.
module tb_clint_mp;

  localparam int unsigned NH = 4;
  localparam int unsigned TD = 4;

  localparam logic [31:0] BASE  = 32'hF000_0000;
  localparam logic [31:0] CTRL  = BASE | 32'hBFF0;
  localparam logic [31:0] T_LO  = BASE | 32'hBFF8;
  localparam logic [31:0] T_HI  = BASE | 32'hBFFC;

  localparam int K_NONE = 0, K_MSIP = 1, K_CLO = 2, K_CHI = 3, K_CTRL = 4, K_TLO = 5, K_THI = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i, we_i;
  logic [31:0]   addr_i, data_i;
  logic [31:0]   data_o;
  logic          data_ready_o, err_o;
  logic [NH-1:0] tmr_irq_o, sft_irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  clint_mp #(.XLEN(32), .CORE_NUMS(NH), .TICK_DIV(TD)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_ready_o (data_ready_o),
    .err_o        (err_o),
    .tmr_irq_o    (tmr_irq_o),
    .sft_irq_o    (sft_irq_o)
  );

  // Reference model state: plain 64-bit time, count of running cycles, register arrays.
  logic [63:0]   m_time;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;
  bit            m_run;
  int unsigned   m_runcyc;
  logic [31:0]   m_shadow;
  logic [31:0]   e_data;
  bit            e_ready, e_err, e_known;
  logic [NH-1:0] e_tmr, e_sft;

  function automatic logic [31:0] msip_a(input int unsigned h);   return BASE | (4 * h); endfunction
  function automatic logic [31:0] cmplo_a(input int unsigned h);  return BASE | (32'h4000 + 8 * h); endfunction
  function automatic logic [31:0] cmphi_a(input int unsigned h);  return BASE | (32'h4004 + 8 * h); endfunction

  function automatic int classify(input logic [31:0] a, output int unsigned h);
    int unsigned o;
    o = 32'(a[15:0]);
    h = 0;
    if (o == 32'hBFF0) return K_CTRL;
    if (o == 32'hBFF8) return K_TLO;
    if (o == 32'hBFFC) return K_THI;
    if ((o % 4) != 0) return K_NONE;
    if (o < 32'h4000) begin
      h = o / 4;
      return (h < NH) ? K_MSIP : K_NONE;
    end
    h = (o - 32'h4000) / 8;
    if (h >= NH) return K_NONE;
    return ((o % 8) == 0) ? K_CLO : K_CHI;
  endfunction

  task automatic model_reset();
    m_time = '0; m_msip = '0; m_run = 1; m_runcyc = 0; m_shadow = '0;
    for (int i = 0; i < NH; i++) m_cmp[i] = '0;
    e_data = '0; e_known = 1; e_ready = 0; e_err = 0; e_tmr = '0; e_sft = '0;
  endtask

  // Advances the model by one clock edge; expectations describe outputs just after that edge.
  task automatic model_step(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit          tick;
    int          k;
    int unsigned h;
    logic [63:0] nt;
    for (int i = 0; i < NH; i++) e_tmr[i] = (m_cmp[i] != 0) && (m_time >= m_cmp[i]);
    e_sft = m_msip;
    tick = m_run && ((m_runcyc % TD) == TD - 1);
    if (m_run) m_runcyc++;
    nt = m_time + (tick ? 64'd1 : 64'd0);
    e_ready = en;
    e_err = 0;
    if (en) begin
      k = classify(a, h);
      e_err = (k == K_NONE);
      if (!we) begin
        case (k)
          K_MSIP:  e_data = {31'b0, m_msip[h]};
          K_CLO:   e_data = m_cmp[h][31:0];
          K_CHI:   e_data = m_cmp[h][63:32];
          K_CTRL:  e_data = {31'b0, m_run};
          K_TLO:   e_data = m_time[31:0];
          K_THI:   e_data = m_shadow;
          default: e_data = '0;
        endcase
        if (k == K_TLO) m_shadow = m_time[63:32];
        e_known = 1;
      end else begin
        e_known = 0;
        case (k)
          K_MSIP: m_msip[h] = d[0];
          K_CLO:  m_cmp[h][31:0] = d;
          K_CHI:  m_cmp[h][63:32] = d;
          K_CTRL: m_run = d[0];
          K_TLO:  nt = {m_time[63:32], d};
          K_THI:  nt = {d, m_time[31:0] + (tick ? 32'd1 : 32'd0)};
          default: ;
        endcase
      end
    end
    m_time = nt;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, step model, sample 1 time unit after the edge.
  task automatic cyc(input bit en, input bit we, input logic [31:0] a, input logic [31:0] d);
    en_i = en; we_i = we; addr_i = a; data_i = d;
    @(posedge clk);
    model_step(en, we, a, d);
    #1;
    en_i = 0; we_i = 0;
    chk("ready", 64'(data_ready_o), 64'(e_ready));
    if (e_ready) chk("err", 64'(err_o), 64'(e_err));
    if (e_known) chk("rdata", 64'(data_o), 64'(e_data));
    chk("tmr_irq", 64'(tmr_irq_o), 64'(e_tmr));
    chk("sft_irq", 64'(sft_irq_o), 64'(e_sft));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 1, a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cyc(1, 0, a, '0);
    v = data_o;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input bit ee);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.exp_data = ed; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1:    return msip_a($urandom_range(0, 5));
      2, 3:    return cmplo_a($urandom_range(0, 5));
      4:       return cmphi_a($urandom_range(0, 5));
      5:       return CTRL;
      6:       return T_LO;
      7:       return T_HI;
      8:       return BASE | 32'h1234;
      default: return BASE | 32'h0000_4000 | 32'($urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 200));
      2:       return 32'h0;
      default: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [63:0] exp_t;
    int          reach, rise;
    bit          found;

    en_i = 0; we_i = 0; addr_i = '0; data_i = '0;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_ready", 64'(data_ready_o), 64'd0);
    chk("rst_data", 64'(data_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_tmr", 64'(tmr_irq_o), 64'd0);
    chk("rst_sft", 64'(sft_irq_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();

    // Prescaled count, then stop.
    idle(40);
    rd(T_LO, v);
    chk("mtime_after_40", 64'(v), 64'd10);
    wr(CTRL, 32'h0);
    idle(20);
    rd(T_LO, v);
    chk("mtime_stopped", 64'(v), 64'd10);
    wr(CTRL, 32'h1);

    add(1, CTRL,              32'h0,         32'h0,         0);
    add(0, CTRL,              32'h0,         32'h0,         0);
    add(1, msip_a(3),         32'hFFFF_FFFF, 32'h0,         0);
    add(0, msip_a(3),         32'h0,         32'h1,         0);
    add(0, msip_a(0),         32'h0,         32'h0,         0);
    add(0, msip_a(2),         32'h0,         32'h0,         0);
    add(0, BASE | 32'h0010,   32'h0,         32'h0,         1);
    add(0, BASE | 32'h4020,   32'h0,         32'h0,         1);
    add(0, BASE | 32'h0002,   32'h0,         32'h0,         1);
    add(1, BASE | 32'h1234,   32'hDEAD_BEEF, 32'h0,         1);
    add(0, BASE | 32'h1234,   32'h0,         32'h0,         1);
    add(1, cmplo_a(1),        32'h1234_5678, 32'h0,         0);
    add(0, cmplo_a(1),        32'h0,         32'h1234_5678, 0);
    add(0, cmphi_a(1),        32'h0,         32'h0,         0);
    add(0, BASE | 32'hBFF4,   32'h0,         32'h0,         1);
    add(1, msip_a(3),         32'h0,         32'h0,         0);
    add(0, msip_a(3),         32'h0,         32'h0,         0);
    add(1, CTRL,              32'h1,         32'h0,         0);
    add(0, CTRL,              32'h0,         32'h1,         0);
    foreach (vecs[i]) begin
      cyc(1, vecs[i].we, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_err", i), 64'(err_o), 64'(vecs[i].exp_err));
      if (!vecs[i].we) chk($sformatf("vec%0d_data", i), 64'(data_o), 64'(vecs[i].exp_data));
    end

    // Timer IRQ on hart 2 only, one cycle after mtime reaches the compare value.
    wr(cmplo_a(2), 32'd100);
    wr(cmphi_a(2), 32'd0);
    reach = -1; rise = -1;
    for (int i = 0; i < 1000 && rise < 0; i++) begin
      idle(1);
      if (reach < 0 && m_time == 64'd100) reach = i;
      if (rise < 0 && tmr_irq_o != '0) rise = i;
    end
    chk("irq2_rise_seen", 64'(rise >= 0), 64'd1);
    if (rise >= 0) begin
      chk("irq2_only", 64'(tmr_irq_o), 64'(4'b0100));
      chk("irq2_latency", 64'(rise - reach), 64'd1);
    end
    wr(cmplo_a(2), 32'd0);
    chk("irq2_held", 64'(tmr_irq_o), 64'(4'b0100));
    idle(1);
    chk("irq2_drop", 64'(tmr_irq_o), 64'd0);

    // Low-word carry and shadowed high read.
    wr(CTRL, 32'h0);
    wr(T_HI, 32'h0);
    wr(T_LO, 32'hFFFF_FFFE);
    wr(CTRL, 32'h1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_time[31:0] == 32'hFFFF_FFFF) begin
        rd(T_LO, v);
        chk("carry_lo", 64'(v), 64'hFFFF_FFFF);
        rd(T_HI, v);
        chk("shadow_hi", 64'(v), 64'd0);
        found = 1;
      end else begin
        idle(1);
      end
    end
    chk("carry_window_seen", 64'(found), 64'd1);
    idle(8);
    rd(T_LO, v);
    rd(T_HI, v);
    chk("live_hi", 64'(v), 64'd1);

    // A stop written on a tick edge still lets that tick count.
    for (int i = 0; i < 10 && !(m_run && (m_runcyc % TD) == TD - 1); i++) idle(1);
    exp_t = m_time + 64'd1;
    wr(CTRL, 32'h0);
    idle(6);
    rd(T_LO, v);
    chk("stop_tick_counts", 64'(v), 64'(exp_t[31:0]));
    wr(CTRL, 32'h1);

    // Back-to-back unrelated writes must not stall the timer.
    for (int i = 0; i < 12; i++) wr(msip_a(0), 32'(i & 1));
    rd(T_LO, v);

    for (int i = 0; i < 400; i++) begin
      a = rand_addr();
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else if (a == CTRL) begin
        cyc(1, 1'($urandom_range(0, 1)), a, 32'($urandom_range(0, 3) != 0));
      end else begin
        cyc(1, 1'($urandom_range(0, 1)), a, rand_data());
      end
    end

    // Reset landing in the response cycle of a read.
    wr(msip_a(1), 32'h1);
    wr(CTRL, 32'h0);
    idle(1);
    cyc(1, 0, CTRL, '0);
    #2 rst_n = 0;
    #1;
    chk("abort_ready", 64'(data_ready_o), 64'd0);
    chk("abort_tmr", 64'(tmr_irq_o), 64'd0);
    chk("abort_sft", 64'(sft_irq_o), 64'd0);
    chk("abort_data", 64'(data_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    idle(3);
    rd(CTRL, v);
    chk("run_after_reset", 64'(v), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
